// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 device-clocked
// bits, ACK sample and bus-idle wait, with open-drain drive through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_NACK = 2'b10;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  state_t          state;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_q;
  logic            clk_s, data_s, fe, tmo;
  logic [9:0]      frame;
  logic [3:0]      idx;
  logic [CW-1:0]   cnt;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_q     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_q     <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fe     = clk_q & ~clk_s;
  assign tmo    = (cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      frame       <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            idx        <= '0;
            err_code   <= 2'b00;
            cnt        <= INH_LAST;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == '0) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          cnt        <= '0;
          state      <= SEND;
        end
        SEND: begin
          if (fe) begin
            ps2_data_oe <= ~frame[idx];
            cnt         <= '0;
            if (idx == 4'd9) state <= ACK;
            else             idx   <= idx + 1'b1;
          end else if (tmo) begin
            ps2_data_oe <= 1'b0;
            err         <= 1'b1;
            err_code    <= ERR_TMO;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          if (fe) begin
            cnt <= '0;
            if (!data_s) begin
              state <= WAIT_IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_NACK;
              state    <= IDLE;
            end
          end else if (tmo) begin
            err      <= 1'b1;
            err_code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (fe) begin
            cnt <= '0;
          end else if (tmo) begin
            err      <= 1'b1;
            err_code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign rx_inhibit = busy;
  assign tx_ready   = (state == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model plus a timeline model of the expected
// line drive, checked every cycle, and literal expectations per frame.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 500;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .rx_inhibit(rx_inhibit), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Timeline model: accept cycle, device falling-edge cycles, expected pulse cycles.
  bit         m_on = 0, m_tmo = 0;
  int         m_acc = 0, m_done_at = -1, m_err_at = -1;
  logic [1:0] m_code = 2'b00;
  logic [9:0] m_bits = '0;
  int         m_fe[$];

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  always @(negedge clk) begin : cmp
    int p, k, endc;
    logic e_clk, e_data, e_busy;
    if (m_on && rstn) begin
      p = cyc;
      k = 0;
      foreach (m_fe[i]) if (m_fe[i] + 3 <= p) k++;
      endc   = (m_done_at >= 0) ? m_done_at : m_err_at;
      e_clk  = (p >= m_acc) && (p <= m_acc + INH);
      if (p < m_acc + INH)                          e_data = 1'b0;
      else if (m_tmo && p >= m_acc + INH + 1 + TMO) e_data = 1'b0;
      else if (k == 0)                              e_data = 1'b1;
      else if (k <= 10)                             e_data = ~m_bits[k-1];
      else                                          e_data = 1'b0;
      e_busy = (p >= m_acc) && (endc < 0 || p < endc);
      chk("clk_oe", ps2_clk_oe, e_clk);
      chk("data_oe", ps2_data_oe, e_data);
      chk("busy", busy, e_busy);
      chk("rx_inhibit", rx_inhibit, e_busy);
      chk("tx_ready", tx_ready, !e_busy);
      chk("done", done, p == m_done_at);
      chk("err", err, p == m_err_at);
      if (p >= m_acc)
        chk("err_code", err_code, (m_err_at >= 0 && p >= m_err_at) ? m_code : 2'b00);
    end
  end

  logic [9:0] r_rx;
  bit         r_lata, r_latb, r_dev_ok, r_seen, r_rdy_next;
  int         r_nd, r_ne, r_nclk, r_nboth, r_t;
  logic [1:0] r_code, r_oe_next;

  task automatic start_req(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    m_acc = cyc + 1; m_bits = frame_of(d); m_fe.delete();
    m_done_at = -1; m_err_at = -1; m_code = 2'b00; m_tmo = 0; m_on = 1;
  endtask

  // Device: waits for the host's request-to-send, then clocks nfe falling edges.
  task automatic dev_frame(input int nfe, input bit ack);
    bit seen_hi = 0;
    r_rx = '0; r_lata = 0; r_latb = 0; r_dev_ok = 0;
    for (int t = 0; t < 200 && !r_dev_ok; t++) begin
      @(negedge clk);
      if (ps2_clk_oe) seen_hi = 1;
      else if (seen_hi) r_dev_ok = 1;
    end
    if (r_dev_ok) begin
      repeat (H) @(negedge clk);
      for (int i = 0; i < nfe; i++) begin
        if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
        dev_clk = 1'b0;
        m_fe.push_back(cyc);
        if (i == 10 && !ack) begin m_err_at = cyc + 3; m_code = 2'b10; end
        if (i == 0) begin
          repeat (2) @(negedge clk);
          r_lata = ps2_data_oe;
          @(negedge clk);
          r_latb = ps2_data_oe;
          repeat (H - 3) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        dev_clk = 1'b1;
        if (i == 10) begin
          dev_data = 1'b1;
          if (ack) m_done_at = cyc + 3;
        end else begin
          r_rx[i] = ps2_data_in;
        end
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic watch(input int budget, input bit hold);
    r_nd = 0; r_ne = 0; r_nclk = 0; r_nboth = 0; r_t = -1; r_seen = 0; r_code = 2'b11;
    r_rdy_next = 0; r_oe_next = 2'b11;
    for (int t = 0; t < budget && !r_seen; t++) begin
      @(negedge clk);
      if (t == 0 && !hold) tx_valid = 1'b0;
      if (ps2_clk_oe) r_nclk++;
      if (ps2_clk_oe && ps2_data_oe) r_nboth++;
      if (done) r_nd++;
      if (err) r_ne++;
      if (done || err) begin
        r_seen = 1; r_t = t; r_code = err_code;
        if (hold) tx_valid = 1'b0;
      end
    end
    if (r_seen) begin
      @(negedge clk);
      r_rdy_next = tx_ready;
      r_oe_next  = {ps2_clk_oe, ps2_data_oe};
    end
    chk("pulse_seen", r_seen, 1);
  endtask

  task automatic frame(input logic [7:0] d, input int nfe, input bit ack, input bit hold,
                       input bit timeout);
    start_req(d);
    if (timeout) begin
      m_tmo = 1; m_err_at = m_acc + INH + 1 + TMO; m_code = 2'b01;
      watch(2000, hold);
    end else begin
      fork
        dev_frame(nfe, ack);
        watch(2000, hold);
      join
      chk("dev_saw_rts", r_dev_ok, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nbusy;
    repeat (2) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 2'b00);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: data 1,0,1,1,0,1,1,1 parity 1 stop 1; inhibit window and latency
    frame(8'hED, 11, 1, 0, 0);
    chk("ed_rx_bits", r_rx, 10'h3ED);
    chk("ed_done", r_nd, 1);
    chk("ed_err", r_ne, 0);
    chk("ed_err_code", r_code, 2'b00);
    chk("ed_clk_oe_cycles", r_nclk, 21);
    chk("ed_start_cycles", r_nboth, 1);
    chk("ed_lat_2cyc", r_lata, 1);
    chk("ed_lat_3cyc", r_latb, 0);
    repeat (10) @(negedge clk);

    frame(8'h00, 11, 1, 0, 0);
    chk("p00_rx_bits", r_rx, 10'h300);
    chk("p00_parity", r_rx[8], 1);
    frame(8'hFF, 11, 1, 0, 0);
    chk("pff_rx_bits", r_rx, 10'h3FF);
    chk("pff_done", r_nd, 1);

    // no ACK
    frame(8'h3C, 11, 0, 0, 0);
    chk("nack_err", r_ne, 1);
    chk("nack_done", r_nd, 0);
    chk("nack_code", r_code, 2'b10);
    chk("nack_ready_next", r_rdy_next, 1);
    chk("nack_oe_next", r_oe_next, 2'b00);
    repeat (10) @(negedge clk);

    // device never clocks
    frame(8'hF4, 0, 1, 0, 1);
    chk("tmo_err", r_ne, 1);
    chk("tmo_done", r_nd, 0);
    chk("tmo_code", r_code, 2'b01);
    chk("tmo_pulse_cycle", r_t, INH + 1 + TMO);
    chk("tmo_oe_next", r_oe_next, 2'b00);
    chk("tmo_ready_next", r_rdy_next, 1);
    repeat (10) @(negedge clk);

    // tx_valid held through the frame: sent once
    frame(8'h5A, 11, 1, 1, 0);
    chk("held_rx_bits", r_rx, 10'h35A);
    chk("held_done", r_nd, 1);
    nbusy = 0;
    repeat (60) begin @(negedge clk); if (busy) nbusy++; end
    chk("held_no_resend", nbusy, 0);

    // reset mid-SEND after 4 bits (bit 3 of 0xF4 is 0, so data is being pulled)
    start_req(8'hF4);
    fork
      begin @(negedge clk); tx_valid = 1'b0; end
      dev_frame(4, 1);
    join
    chk("abort_dev_saw_rts", r_dev_ok, 1);
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_data_oe", ps2_data_oe, 1);
    m_on = 0;
    #2 rstn = 1'b0;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    nbusy = 0;
    repeat (3) begin @(negedge clk); if (done || err) nbusy++; end
    chk("abort_no_pulse", nbusy, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    frame(8'hF4, 11, 1, 0, 0);
    chk("f4_rx_bits", r_rx, 10'h2F4);
    chk("f4_done", r_nd, 1);
    chk("f4_err_code", r_code, 2'b00);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
